// File: rtl/emac_tx_frame_arbiter.sv
// Round-robin frame arbiter: merges NUM_CH byte-wide AXI-S sources onto one MAC TX stream,
// truncating frames longer than MAX_LEN and discarding the remainder of a truncated frame.
module emac_tx_frame_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 1514,
  parameter int LEN_W   = 11,
  parameter int CNT_W   = 16
) (
  input  logic                       tx_fifo_clk,
  input  logic                       glbl_rst,
  input  logic                       en,
  input  logic [NUM_CH*8-1:0]        s_tdata,
  input  logic [NUM_CH-1:0]          s_tvalid,
  input  logic [NUM_CH-1:0]          s_tlast,
  output logic [NUM_CH-1:0]          s_tready,
  output logic [7:0]                 tx_axis_fifo_tdata,
  output logic                       tx_axis_fifo_tvalid,
  output logic                       tx_axis_fifo_tlast,
  input  logic                       tx_axis_fifo_tready,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       busy,
  output logic [CNT_W-1:0]           frame_count,
  output logic [CNT_W-1:0]           trunc_count
);
  localparam int AW = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     active_ch_q, active_ch_d;
  logic [AW-1:0]     last_grant_q, last_grant_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]  frame_count_q, frame_count_d;
  logic [CNT_W-1:0]  trunc_count_q, trunc_count_d;

  logic [NUM_CH-1:0][7:0] s_data_v;
  logic [7:0]             sel_data;
  logic                   sel_valid, sel_last, out_hs, at_max;
  logic                   grant_found;
  logic [AW-1:0]          grant_idx;

  function automatic logic [AW-1:0] wrap_idx(input logic [AW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_CH;
    return AW'(s);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign s_data_v  = s_tdata;
  assign sel_data  = s_data_v[active_ch_q];
  assign sel_valid = s_tvalid[active_ch_q];
  assign sel_last  = s_tlast[active_ch_q];
  assign at_max    = (byte_cnt_q == LEN_W'(MAX_LEN - 1));
  assign out_hs    = (state_q == PASS) && sel_valid && tx_axis_fifo_tready;

  // Search starts one past the last completed grant so every channel gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!grant_found && s_tvalid[wrap_idx(last_grant_q, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(last_grant_q, k);
      end
    end
  end

  always_comb begin
    s_tready            = '0;
    tx_axis_fifo_tdata  = '0;
    tx_axis_fifo_tvalid = 1'b0;
    tx_axis_fifo_tlast  = 1'b0;
    case (state_q)
      PASS: begin
        tx_axis_fifo_tdata     = sel_data;
        tx_axis_fifo_tvalid    = sel_valid;
        tx_axis_fifo_tlast     = sel_last | at_max;
        s_tready[active_ch_q]  = tx_axis_fifo_tready;
      end
      DROP:    s_tready[active_ch_q] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    active_ch_d   = active_ch_q;
    last_grant_d  = last_grant_q;
    byte_cnt_d    = byte_cnt_q;
    frame_count_d = frame_count_q;
    trunc_count_d = trunc_count_q;
    case (state_q)
      IDLE: begin
        if (en && grant_found) begin
          state_d     = PASS;
          active_ch_d = grant_idx;
          byte_cnt_d  = '0;
        end
      end
      PASS: begin
        if (out_hs) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (sel_last) begin
            state_d       = IDLE;
            frame_count_d = sat_inc(frame_count_q);
            last_grant_d  = active_ch_q;
          end else if (at_max) begin
            state_d       = DROP;
            frame_count_d = sat_inc(frame_count_q);
            trunc_count_d = sat_inc(trunc_count_q);
          end
        end
      end
      DROP: begin
        if (sel_valid && sel_last) begin
          state_d      = IDLE;
          last_grant_d = active_ch_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_fifo_clk or posedge glbl_rst) begin
    if (glbl_rst) begin
      state_q       <= IDLE;
      active_ch_q   <= '0;
      last_grant_q  <= AW'(NUM_CH - 1);
      byte_cnt_q    <= '0;
      frame_count_q <= '0;
      trunc_count_q <= '0;
    end else begin
      state_q       <= state_d;
      active_ch_q   <= active_ch_d;
      last_grant_q  <= last_grant_d;
      byte_cnt_q    <= byte_cnt_d;
      frame_count_q <= frame_count_d;
      trunc_count_q <= trunc_count_d;
    end
  end

  assign active_ch   = active_ch_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;
  assign trunc_count = trunc_count_q;
endmodule

// File: tb/tb_emac_tx_frame_arbiter.sv
// Bench for emac_tx_frame_arbiter: per-channel source models, an output scoreboard,
// a vector table of single-frame cases and hand-written multi-cycle sequences.
module tb_emac_tx_frame_arbiter;
  localparam int NCH = 4, MAXL = 8, LW = 4, CW = 4, DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst, en, tready;
  logic [NCH*8-1:0]  s_tdata;
  logic [NCH-1:0]    s_tvalid, s_tlast, s_tready;
  logic [7:0]        m_tdata;
  logic              m_tvalid, m_tlast, busy;
  logic [1:0]        active_ch;
  logic [CW-1:0]     frame_count, trunc_count;

  always #5 clk = ~clk;

  emac_tx_frame_arbiter #(.NUM_CH(NCH), .MAX_LEN(MAXL), .LEN_W(LW), .CNT_W(CW)) dut (
    .tx_fifo_clk(clk), .glbl_rst(rst), .en(en),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .tx_axis_fifo_tdata(m_tdata), .tx_axis_fifo_tvalid(m_tvalid),
    .tx_axis_fifo_tlast(m_tlast), .tx_axis_fifo_tready(tready),
    .active_ch(active_ch), .busy(busy), .frame_count(frame_count), .trunc_count(trunc_count));

  typedef struct packed { logic [7:0] data; logic last; logic [1:0] ch; } beat_t;
  typedef struct { int ch; int len; int exp_drops; int exp_trunc_inc; } vec_t;

  beat_t      sb[$];
  int         beat_cyc[$];
  logic [8:0] mem [NCH][DEPTH];
  int         head[NCH], tail[NCH];
  int         checks = 0, failures = 0, cyc = 0, drops = 0;
  logic       prev_stall = 1'b0, prev_last;
  logic [7:0] prev_data;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic bit pending();
    for (int c = 0; c < NCH; c++) if (head[c] != tail[c]) return 1'b1;
    return 1'b0;
  endfunction

  // Expected output: first MAXL bytes, with tlast forced on byte MAXL when the frame is longer.
  task automatic load(input int ch, input int len, input bit push);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      mem[ch][tail[ch]] = {(i == len - 1), d};
      tail[ch]++;
      if (push && i < MAXL)
        sb.push_back('{data: d, last: (i == len - 1) || (i == MAXL - 1), ch: 2'(ch)});
    end
  endtask

  task automatic push_pending(input int ch);
    for (int i = head[ch]; i < tail[ch]; i++)
      if (i - head[ch] < MAXL)
        sb.push_back('{data: mem[ch][i][7:0], last: mem[ch][i][8] || (i - head[ch] == MAXL - 1),
                       ch: 2'(ch)});
  endtask

  task automatic flush();
    for (int c = 0; c < NCH; c++) begin head[c] = 0; tail[c] = 0; end
    sb.delete();
  endtask

  task automatic wait_done(input string name, input int budget, input bit need_src, input bit bp);
    int n = 0;
    while ((sb.size() != 0 || busy || (need_src && pending())) && n < budget) begin
      if (bp) tready = (n % 4 == 0 || n % 4 == 3);
      step();
      n++;
    end
    tready = 1'b1;
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got %0d cycles required < %0d", name, n, budget);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    flush();
    chk("rst_busy", busy, 0);
    chk("rst_active_ch", active_ch, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_trunc_count", trunc_count, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_s_tready", s_tready, 0);
    step();
    rst = 1'b0;
    step();
  endtask

  // Source models and output monitor: sample at negedge, advance sources just after posedge.
  initial begin
    s_tdata = '0; s_tvalid = '0; s_tlast = '0;
    forever begin
      logic [NCH-1:0] hs;
      @(negedge clk);
      cyc++;
      hs = s_tvalid & s_tready;
      if (m_tvalid && tready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: got data %0d required no beat", m_tdata);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("out_data", m_tdata, e.data);
          chk("out_last", m_tlast, e.last);
          chk("out_ch", active_ch, e.ch);
          beat_cyc.push_back(cyc);
        end
      end
      if (prev_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, prev_data);
        chk("stall_tlast", m_tlast, prev_last);
      end
      if (m_tvalid) chk("src_ready_mirror", s_tready, tready ? (1 << active_ch) : 0);
      if (!m_tvalid && hs != 0) drops++;
      prev_stall = m_tvalid && !tready && !rst;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (hs[c]) head[c]++;
        if (head[c] < tail[c]) begin
          s_tvalid[c] = 1'b1;
          {s_tlast[c], s_tdata[c*8 +: 8]} = mem[c][head[c]];
        end else begin
          s_tvalid[c] = 1'b0; s_tlast[c] = 1'b0; s_tdata[c*8 +: 8] = '0;
        end
      end
    end
  end

  initial begin
    vec_t vt[5];
    int   exp_fc, exp_tc, busy_cnt, n;
    vt[0] = '{ch: 1, len: 12, exp_drops: 4, exp_trunc_inc: 1};
    vt[1] = '{ch: 2, len: 8,  exp_drops: 0, exp_trunc_inc: 0};
    vt[2] = '{ch: 3, len: 9,  exp_drops: 1, exp_trunc_inc: 1};
    vt[3] = '{ch: 0, len: 7,  exp_drops: 0, exp_trunc_inc: 0};
    vt[4] = '{ch: 1, len: 2,  exp_drops: 0, exp_trunc_inc: 0};
    rst = 1'b1; en = 1'b0; tready = 1'b1;
    do_reset();
    en = 1'b1;

    // Round robin: five 3-byte frames served 0,1,2,3,0, each 3 beats then one idle cycle.
    beat_cyc.delete();
    load(0, 3, 1); load(1, 3, 1); load(2, 3, 1); load(3, 3, 1); load(0, 3, 1);
    wait_done("rr", 200, 1, 0);
    chk("rr_frame_count", frame_count, 5);
    chk("rr_trunc_count", trunc_count, 0);
    chk("rr_beats", beat_cyc.size(), 15);
    if (beat_cyc.size() == 15)
      for (int k = 1; k < 15; k++) chk("rr_timing", beat_cyc[k] - beat_cyc[0], k + k / 3);

    // Single-frame vectors: truncation, exact length, boundaries.
    do_reset();
    exp_fc = 0; exp_tc = 0;
    for (int i = 0; i < 5; i++) begin
      drops = 0;
      load(vt[i].ch, vt[i].len, 1);
      wait_done("vec", 200, 1, 0);
      exp_fc++;
      exp_tc += vt[i].exp_trunc_inc;
      chk("vec_drops", drops, vt[i].exp_drops);
      chk("vec_frame_count", frame_count, exp_fc);
      chk("vec_trunc_count", trunc_count, exp_tc);
    end

    // Backpressure: tready pattern 1,0,0,1 repeating during a frame.
    load(2, 6, 1);
    wait_done("bp", 300, 1, 1);
    chk("bp_frame_count", frame_count, exp_fc + 1);

    // Enable drop mid-frame: frame on channel 2 completes, channel 0 waits.
    do_reset();
    load(2, 6, 1);
    n = 0;
    while (sb.size() > 4 && n < 50) begin step(); n++; end
    chk("en_started", (sb.size() <= 4) ? 1 : 0, 1);
    en = 1'b0;
    load(0, 3, 0);
    wait_done("en_off", 100, 0, 0);
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); if (busy || m_tvalid) busy_cnt++; end
    chk("en_no_grant", busy_cnt, 0);
    chk("en_frame_count", frame_count, 1);
    en = 1'b1;
    push_pending(0);
    wait_done("en_on", 100, 1, 0);
    chk("en_resume_count", frame_count, 2);

    // Reset mid-frame on channel 3: outputs drop at once, next grant goes to channel 0.
    load(3, 6, 1);
    n = 0;
    while (sb.size() > 3 && n < 50) begin step(); n++; end
    rst = 1'b1;
    #1;
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_tready", s_tready, 0);
    chk("midrst_frame_count", frame_count, 0);
    @(negedge clk);
    flush();
    step();
    rst = 1'b0;
    step();
    load(0, 3, 1); load(3, 3, 1);
    wait_done("postrst", 100, 1, 0);
    chk("postrst_frame_count", frame_count, 2);
    chk("postrst_trunc_count", trunc_count, 0);

    // Saturation: 20 frames into a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) load(1, 2, 1);
    wait_done("sat", 500, 1, 0);
    chk("sat_frame_count", frame_count, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish before 2000000");
    $fatal(1);
  end
endmodule
